// File: rtl/pe_array_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pe_array_ctrl_pkg
//  Description : Shared types, widths and helpers for the PE array task
//                sequencer (state encoding, PE config record, bit widths).
//  Revision    : 1.0 - initial release
// ============================================================================
package pe_array_ctrl_pkg;

    // PEs per accumulation-buffer readout group
    localparam int c_GRP_SIZE = 4;

    // Bits needed to index n entries (never less than one bit)
    function automatic int bw(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Number of readout groups for a given PE count
    function automatic int grp_num(input int pe_num);
        return pe_num / c_GRP_SIZE;
    endfunction

    // Width of the group select for a given PE count
    function automatic int grp_w(input int pe_num);
        return bw(grp_num(pe_num));
    endfunction

    // Width of the abuf address for a given buffer depth
    function automatic int addr_w(input int buf_depth);
        return bw(buf_depth);
    endfunction

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SWITCH    = 3'd1,
        ST_START     = 3'd2,
        ST_RUN       = 3'd3,
        ST_FLUSH     = 3'd4,
        ST_DRAIN     = 3'd5,
        ST_WAIT_PIPE = 3'd6
    } state_t;

    // Per-task PE configuration, held on the array config port
    typedef struct packed {
        logic [2:0] mode;
        logic [7:0] idx_cnt;
        logic [7:0] trip_cnt;
        logic       is_new;
        logic [3:0] pad_code;
        logic       cut_y;
    } cfg_t;

endpackage
`default_nettype wire

// File: rtl/pe_array_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : pe_array_ctrl_if
//  Description : Task descriptor handshake between the layer scheduler
//                (master) and the PE array sequencer (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface pe_array_ctrl_if #(
    parameter int PE_NUM = 32
);
    logic              task_valid;
    logic              task_ready;
    logic [PE_NUM-1:0] task_mask;
    logic [2:0]        task_mode;
    logic [7:0]        task_idx_cnt;
    logic [7:0]        task_trip_cnt;
    logic              task_is_new;
    logic [3:0]        task_pad_code;
    logic              task_cut_y;
    logic              task_last;

    modport master (
        output task_valid, task_mask, task_mode, task_idx_cnt, task_trip_cnt,
               task_is_new, task_pad_code, task_cut_y, task_last,
        input  task_ready
    );

    modport slave (
        input  task_valid, task_mask, task_mode, task_idx_cnt, task_trip_cnt,
               task_is_new, task_pad_code, task_cut_y, task_last,
        output task_ready
    );
endinterface
`default_nettype wire

// File: rtl/pe_drain_seq.sv
`default_nettype none
// ============================================================================
//  Module      : pe_drain_seq
//  Description : Accumulation-buffer drain sequencer. Walks the active groups
//                lowest first, sweeping every buffer address, and delays the
//                (valid, group, address) tag so it lines up with read data.
//  Revision    : 1.0 - initial release
// ============================================================================
module pe_drain_seq
    import pe_array_ctrl_pkg::*;
#(
    parameter  int PE_NUM    = 32,
    parameter  int BUF_DEPTH = 256,
    parameter  int RD_LAT    = 2,
    localparam int GRP_NUM   = grp_num(PE_NUM),
    localparam int GRP_W     = grp_w(PE_NUM),
    localparam int ADDR_W    = addr_w(BUF_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_run,
    input  logic [PE_NUM-1:0] i_mask,
    output logic [GRP_W-1:0]  o_rd_sel,
    output logic [ADDR_W-1:0] o_rd_addr,
    output logic              o_last,
    output logic              o_pipe_busy,
    output logic              o_drain_valid,
    output logic [GRP_W-1:0]  o_drain_grp,
    output logic [ADDR_W-1:0] o_drain_addr
);

    localparam logic [ADDR_W-1:0] c_ADDR_MAX = ADDR_W'(BUF_DEPTH - 1);

    logic [GRP_NUM-1:0] w_grp_active;
    logic [GRP_W-1:0]   w_first_grp;
    logic [GRP_W-1:0]   w_next_grp;
    logic               w_next_found;
    logic               w_addr_end;

    logic [GRP_W-1:0]   r_grp;
    logic [ADDR_W-1:0]  r_addr;
    logic [RD_LAT-1:0]  r_vld;
    logic [GRP_W-1:0]   r_tag_grp  [RD_LAT];
    logic [ADDR_W-1:0]  r_tag_addr [RD_LAT];

    // A group is drained only if at least one of its PEs took part
    generate
        for (genvar g = 0; g < GRP_NUM; g++) begin : g_grp_active
            assign w_grp_active[g] = |i_mask[g*c_GRP_SIZE +: c_GRP_SIZE];
        end
    endgenerate

    // Lowest active group, and lowest active group above the current one
    always_comb begin
        w_first_grp  = '0;
        w_next_grp   = '0;
        w_next_found = 1'b0;
        for (int g = GRP_NUM - 1; g >= 0; g--) begin
            if (w_grp_active[g]) begin
                w_first_grp = GRP_W'(g);
            end
            if (w_grp_active[g] && (g > int'(r_grp))) begin
                w_next_grp   = GRP_W'(g);
                w_next_found = 1'b1;
            end
        end
    end

    assign w_addr_end = (r_addr == c_ADDR_MAX);
    assign o_last     = i_run && w_addr_end && !w_next_found;

    // Group/address counters: loaded on flush, stepped once per drain cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_grp  <= '0;
            r_addr <= '0;
        end else if (i_load) begin
            r_grp  <= w_first_grp;
            r_addr <= '0;
        end else if (i_run) begin
            if (w_addr_end) begin
                r_addr <= '0;
                r_grp  <= w_next_found ? w_next_grp : '0;
            end else begin
                r_addr <= r_addr + 1'b1;
            end
        end
    end

    // Tag pipeline matching the array read latency
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                r_tag_grp[i]  <= '0;
                r_tag_addr[i] <= '0;
            end
        end else begin
            r_vld[0]      <= i_run;
            r_tag_grp[0]  <= r_grp;
            r_tag_addr[0] <= r_addr;
            for (int i = 1; i < RD_LAT; i++) begin
                r_vld[i]      <= r_vld[i-1];
                r_tag_grp[i]  <= r_tag_grp[i-1];
                r_tag_addr[i] <= r_tag_addr[i-1];
            end
        end
    end

    assign o_rd_sel      = r_grp;
    assign o_rd_addr     = r_addr;
    assign o_pipe_busy   = |r_vld;
    assign o_drain_valid = r_vld[RD_LAT-1];
    assign o_drain_grp   = r_tag_grp[RD_LAT-1];
    assign o_drain_addr  = r_tag_addr[RD_LAT-1];

endmodule
`default_nettype wire

// File: rtl/pe_array_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pe_array_ctrl
//  Description : PE array task sequencer. Accepts a task descriptor, pulses
//                the ping-pong switches and start for the selected PEs, waits
//                for all their dones and, on the last task of an accumulation,
//                drains the accumulation buffers group by group.
//  Revision    : 1.0 - initial release
// ============================================================================
module pe_array_ctrl
    import pe_array_ctrl_pkg::*;
#(
    parameter  int PE_NUM    = 32,
    parameter  int BUF_DEPTH = 256,
    parameter  int RD_LAT    = 2,
    localparam int GRP_W     = grp_w(PE_NUM),
    localparam int ADDR_W    = addr_w(BUF_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    pe_array_ctrl_if.slave    task_if,
    output logic [2:0]        mode,
    output logic [7:0]        idx_cnt,
    output logic [7:0]        trip_cnt,
    output logic              is_new,
    output logic [3:0]        pad_code,
    output logic              cut_y,
    output logic [PE_NUM-1:0] switch_d,
    output logic [PE_NUM-1:0] switch_p,
    output logic [PE_NUM-1:0] switch_i,
    output logic [PE_NUM-1:0] switch_a,
    output logic [PE_NUM-1:0] start,
    input  logic [PE_NUM-1:0] done,
    output logic [GRP_W-1:0]  rd_sel,
    output logic [ADDR_W-1:0] abuf_rd_addr,
    output logic              drain_valid,
    output logic [GRP_W-1:0]  drain_grp,
    output logic [ADDR_W-1:0] drain_addr,
    output logic              busy
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [PE_NUM-1:0] r_mask;
    cfg_t              r_cfg;
    logic              r_last;
    logic [PE_NUM-1:0] r_done_seen;

    logic              w_accept;
    logic [PE_NUM-1:0] w_done_acc;
    logic              w_all_done;
    logic              w_drain_load;
    logic              w_drain_run;
    logic              w_drain_last;
    logic              w_pipe_busy;

    assign w_accept   = (r_state == ST_IDLE) && task_if.task_valid;
    // Include this cycle's dones so a final done ends RUN on the same edge
    assign w_done_acc = r_done_seen | (done & r_mask);
    assign w_all_done = &(w_done_acc | ~r_mask);

    // State register, descriptor latch and done accumulation
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_mask      <= '0;
            r_cfg       <= '0;
            r_last      <= 1'b0;
            r_done_seen <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_mask         <= task_if.task_mask;
                r_cfg.mode     <= task_if.task_mode;
                r_cfg.idx_cnt  <= task_if.task_idx_cnt;
                r_cfg.trip_cnt <= task_if.task_trip_cnt;
                r_cfg.is_new   <= task_if.task_is_new;
                r_cfg.pad_code <= task_if.task_pad_code;
                r_cfg.cut_y    <= task_if.task_cut_y;
                r_last         <= task_if.task_last;
                r_done_seen    <= '0;
            end else if (r_state == ST_RUN) begin
                r_done_seen <= w_done_acc;
            end
        end
    end

    // Next-state and per-state pulse outputs
    always_comb begin
        w_state_nxt  = r_state;
        switch_d     = '0;
        switch_p     = '0;
        switch_i     = '0;
        switch_a     = '0;
        start        = '0;
        w_drain_load = 1'b0;
        w_drain_run  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (task_if.task_valid) begin
                    w_state_nxt = (|task_if.task_mask) ? ST_SWITCH : ST_IDLE;
                end
            end
            ST_SWITCH: begin
                switch_d    = r_mask;
                switch_p    = r_mask;
                switch_i    = r_mask;
                switch_a    = r_cfg.is_new ? r_mask : '0;
                w_state_nxt = ST_START;
            end
            ST_START: begin
                start       = r_mask;
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (w_all_done) begin
                    w_state_nxt = r_last ? ST_FLUSH : ST_IDLE;
                end
            end
            ST_FLUSH: begin
                // Swap finished accumulations into the readable bank
                switch_a     = r_mask;
                w_drain_load = 1'b1;
                w_state_nxt  = ST_DRAIN;
            end
            ST_DRAIN: begin
                w_drain_run = 1'b1;
                if (w_drain_last) begin
                    w_state_nxt = ST_WAIT_PIPE;
                end
            end
            ST_WAIT_PIPE: begin
                if (!w_pipe_busy) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    pe_drain_seq #(
        .PE_NUM    (PE_NUM),
        .BUF_DEPTH (BUF_DEPTH),
        .RD_LAT    (RD_LAT)
    ) u_drain (
        .clk           (clk),
        .rst           (rst),
        .i_load        (w_drain_load),
        .i_run         (w_drain_run),
        .i_mask        (r_mask),
        .o_rd_sel      (rd_sel),
        .o_rd_addr     (abuf_rd_addr),
        .o_last        (w_drain_last),
        .o_pipe_busy   (w_pipe_busy),
        .o_drain_valid (drain_valid),
        .o_drain_grp   (drain_grp),
        .o_drain_addr  (drain_addr)
    );

    assign task_if.task_ready = (r_state == ST_IDLE);
    assign busy     = (r_state != ST_IDLE) || w_pipe_busy;
    assign mode     = r_cfg.mode;
    assign idx_cnt  = r_cfg.idx_cnt;
    assign trip_cnt = r_cfg.trip_cnt;
    assign is_new   = r_cfg.is_new;
    assign pad_code = r_cfg.pad_code;
    assign cut_y    = r_cfg.cut_y;

endmodule
`default_nettype wire
